// File: rtl/yuv_to_rgb_pipe.sv
// Three-stage YUV->RGB converter with valid/ready backpressure.
// Coefficient banks switch only on an accepted SOF beat, so a frame never mixes banks.
module yuv_to_rgb_pipe #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 8,
  parameter int COEF_W    = 13,
  parameter int COEF_FRAC = 10,
  parameter int USER_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       y_in,
  input  logic [IN_W-1:0]       u_in,
  input  logic [IN_W-1:0]       v_in,
  input  logic                  in_sof,
  input  logic [USER_W-1:0]     in_user,
  input  logic [1:0]            mode_sel,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [COEF_W-1:0]     cfg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*OUT_W-1:0]    rgb_out,
  output logic                  out_sof,
  output logic [USER_W-1:0]     out_user,
  output logic [1:0]            active_mode
);

  localparam int SH   = COEF_FRAC + IN_W - OUT_W;
  localparam int PW   = IN_W + COEF_W + 1;
  localparam int SW   = PW + 2;
  localparam int RND  = 1 << (SH - 1);
  localparam int MAXV = (1 << OUT_W) - 1;

  typedef struct packed {
    logic [COEF_W-1:0] rv;
    logic [COEF_W-1:0] gu;
    logic [COEF_W-1:0] gv;
    logic [COEF_W-1:0] bu;
  } bank_t;

  localparam bank_t BANK_601 = '{rv: COEF_W'(1167), gu: COEF_W'(404),
                                 gv: COEF_W'(595),  bu: COEF_W'(2081)};
  localparam bank_t BANK_709 = '{rv: COEF_W'(1613), gu: COEF_W'(192),
                                 gv: COEF_W'(479),  bu: COEF_W'(1900)};

  // Handshake: a beat moves on a cycle where valid and ready are both high;
  // the only stall source is a held output beat, and it freezes every stage.
  logic stall, accept;
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  logic        out_valid_q;
  bank_t       shadow_q, bank_q, new_bank, beat_bank;
  logic [1:0]  mode_q, new_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= BANK_601;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    shadow_q.rv <= cfg_data;
        2'd1:    shadow_q.gu <= cfg_data;
        2'd2:    shadow_q.gv <= cfg_data;
        default: shadow_q.bu <= cfg_data;
      endcase
    end
  end

  always_comb begin
    new_mode = (mode_sel == 2'd3) ? 2'd0 : mode_sel;
    new_bank = BANK_601;
    case (new_mode)
      2'd1:    new_bank = BANK_709;
      2'd2:    new_bank = shadow_q;
      default: new_bank = BANK_601;
    endcase
    // The SOF beat itself already uses the bank it is switching to.
    beat_bank = in_sof ? new_bank : bank_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= BANK_601;
      mode_q <= 2'd0;
    end else if (accept && in_sof) begin
      bank_q <= new_bank;
      mode_q <= new_mode;
    end
  end

  // Stage 1 operands
  logic signed [IN_W-1:0]   u_s, v_s;
  logic signed [PW-1:0]     y_d, vrv_d, ugu_d, vgv_d, ubu_d;
  assign u_s = u_in;
  assign v_s = v_in;

  always_comb begin
    y_d   = PW'(signed'({1'b0, y_in})) <<< COEF_FRAC;
    vrv_d = PW'(v_s) * PW'(signed'({1'b0, beat_bank.rv}));
    ugu_d = PW'(u_s) * PW'(signed'({1'b0, beat_bank.gu}));
    vgv_d = PW'(v_s) * PW'(signed'({1'b0, beat_bank.gv}));
    ubu_d = PW'(u_s) * PW'(signed'({1'b0, beat_bank.bu}));
  end

  function automatic logic [OUT_W-1:0] round_clamp(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    t = (s + SW'(RND)) >>> SH;
    if (t[SW-1])             return '0;
    else if (t > SW'(MAXV))  return OUT_W'(MAXV);
    else                     return t[OUT_W-1:0];
  endfunction

  logic                     s1_valid_q, s2_valid_q;
  logic signed [PW-1:0]     s1_y_q, s1_vrv_q, s1_ugu_q, s1_vgv_q, s1_ubu_q;
  logic signed [SW-1:0]     s2_r_q, s2_g_q, s2_b_q, r_d, g_d, b_d;
  logic                     s1_sof_q, s2_sof_q, out_sof_q;
  logic [USER_W-1:0]        s1_user_q, s2_user_q, out_user_q;
  logic [3*OUT_W-1:0]       rgb_q, rgb_d;

  always_comb begin
    r_d   = SW'(s1_y_q) + SW'(s1_vrv_q);
    g_d   = SW'(s1_y_q) - SW'(s1_ugu_q) - SW'(s1_vgv_q);
    b_d   = SW'(s1_y_q) + SW'(s1_ubu_q);
    rgb_d = {round_clamp(s2_r_q), round_clamp(s2_g_q), round_clamp(s2_b_q)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_y_q      <= '0;
      s1_vrv_q    <= '0;
      s1_ugu_q    <= '0;
      s1_vgv_q    <= '0;
      s1_ubu_q    <= '0;
      s2_r_q      <= '0;
      s2_g_q      <= '0;
      s2_b_q      <= '0;
      rgb_q       <= '0;
      s1_sof_q    <= 1'b0;
      s2_sof_q    <= 1'b0;
      out_sof_q   <= 1'b0;
      s1_user_q   <= '0;
      s2_user_q   <= '0;
      out_user_q  <= '0;
    end else if (!stall) begin
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (accept) begin
        s1_y_q    <= y_d;
        s1_vrv_q  <= vrv_d;
        s1_ugu_q  <= ugu_d;
        s1_vgv_q  <= vgv_d;
        s1_ubu_q  <= ubu_d;
        s1_sof_q  <= in_sof;
        s1_user_q <= in_user;
      end
      if (s1_valid_q) begin
        s2_r_q    <= r_d;
        s2_g_q    <= g_d;
        s2_b_q    <= b_d;
        s2_sof_q  <= s1_sof_q;
        s2_user_q <= s1_user_q;
      end
      if (s2_valid_q) begin
        rgb_q      <= rgb_d;
        out_sof_q  <= s2_sof_q;
        out_user_q <= s2_user_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign rgb_out     = rgb_q;
  assign out_sof     = out_sof_q;
  assign out_user    = out_user_q;
  assign active_mode = mode_q;

endmodule

// File: tb/tb_yuv_to_rgb_pipe.sv
// Directed bench for yuv_to_rgb_pipe: latency, arithmetic, clamping, stall,
// frame-synchronous bank switching, user bank and mid-stream reset.
module tb_yuv_to_rgb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [11:0] y_in, u_in, v_in;
  logic        in_sof;
  logic [3:0]  in_user;
  logic [1:0]  mode_sel;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [12:0] cfg_data;
  logic        out_valid, out_ready;
  logic [23:0] rgb_out;
  logic        out_sof;
  logic [3:0]  out_user;
  logic [1:0]  active_mode;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [23:0] got_rgb;
  logic        got_sof;
  logic [3:0]  got_user;
  logic        got_ok;

  yuv_to_rgb_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .u_in(u_in), .v_in(v_in), .in_sof(in_sof), .in_user(in_user),
    .mode_sel(mode_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .rgb_out(rgb_out),
    .out_sof(out_sof), .out_user(out_user), .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  // Drive one beat for one cycle; returns 1ns after the accepting edge.
  task automatic send(input logic [11:0] y, input logic [11:0] u, input logic [11:0] v,
                      input logic sof, input logic [3:0] user);
    @(negedge clk);
    in_valid = 1'b1; y_in = y; u_in = u; v_in = v; in_sof = sof; in_user = user;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // Capture the next output beat (out_ready held high), bounded wait.
  task automatic get_out(input string tag);
    got_ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got_ok = 1'b1; got_rgb = rgb_out; got_sof = out_sof; got_user = out_user;
        break;
      end
    end
    if (!got_ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no out_valid within 12 cycles", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [12:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || rgb_out !== 24'h0 || out_sof !== 1'b0 || out_user !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b rgb=%h sof=%b user=%h required 0", out_valid, rgb_out, out_sof, out_user);
    end
    n_cmp++;
    if (active_mode !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mode: active_mode=%0d in_ready=%b required 0/1", active_mode, in_ready);
    end
  endtask

  task automatic test_gray_latency;
    send(12'd2048, 12'd0, 12'd0, 1'b1, 4'h5);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge1: out_valid=%b required 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge2: out_valid=%b required 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_edge3: out_valid=%b required 1", out_valid); end
    n_cmp++;
    if (rgb_out !== {8'd128, 8'd128, 8'd128} || out_sof !== 1'b1 || out_user !== 4'h5) begin
      n_fail++;
      $display("FAIL gray: rgb=%h sof=%b user=%h required 808080/1/5", rgb_out, out_sof, out_user);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_u_path;
    // Y=2048 U=512 (601): G=(2097152-206848+8192)>>14=115, B=(3162624+8192)>>14=193
    send(12'd2048, 12'd512, 12'd0, 1'b0, 4'h2);
    get_out("u_path");
    n_cmp++;
    if (got_rgb !== {8'd128, 8'd115, 8'd193}) begin
      n_fail++;
      $display("FAIL u_path: rgb=%h required %h", got_rgb, {8'd128, 8'd115, 8'd193});
    end
  endtask

  task automatic test_clamp;
    // High clamp: R=402->255, G=(4193280-1217965+8192)>>14=182, B=256->255
    send(12'd4095, 12'd0, 12'd2047, 1'b0, 4'h1);
    // Low clamp: R negative->0, G=(1218560+8192)>>14=74, B=0
    send(12'd0, 12'd0, 12'h800, 1'b0, 4'h2);
    get_out("clamp_hi");
    n_cmp++;
    if (got_rgb !== {8'd255, 8'd182, 8'd255}) begin
      n_fail++;
      $display("FAIL clamp_hi: rgb=%h required %h", got_rgb, {8'd255, 8'd182, 8'd255});
    end
    get_out("clamp_lo");
    n_cmp++;
    if (got_rgb !== {8'd0, 8'd74, 8'd0} || got_user !== 4'h2) begin
      n_fail++;
      $display("FAIL clamp_lo: rgb=%h user=%h required %h/2", got_rgb, got_user, {8'd0, 8'd74, 8'd0});
    end
  endtask

  task automatic test_stall;
    int sent = 0;
    int rcvd = 0;
    logic        was_stall = 1'b0;
    logic [23:0] held;
    logic [7:0]  n;
    held = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 8) begin
        in_valid = 1'b1; y_in = 12'(16 * (20 + sent)); u_in = 12'd0; v_in = 12'd0;
        in_sof = (sent == 0); in_user = 4'(sent);
      end else begin
        in_valid = 1'b0; in_sof = 1'b0;
      end
      #1;
      if (was_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || rgb_out !== held) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b rgb=%h required 1/%h", out_valid, rgb_out, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n = 8'(20 + rcvd);
        n_cmp++;
        if (rgb_out !== {n, n, n} || out_user !== 4'(rcvd)) begin
          n_fail++;
          $display("FAIL stall_order: beat %0d rgb=%h user=%h required %h/%h", rcvd, rgb_out, out_user, {n, n, n}, 4'(rcvd));
        end
        rcvd++;
      end
      was_stall = out_valid && !out_ready;
      held = rgb_out;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (rcvd != 8) begin n_fail++; $display("FAIL stall_count: received %0d required 8", rcvd); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_extra: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_mode_switch;
    mode_sel = 2'd0;
    send(12'd2048, 12'd0, 12'd1024, 1'b1, 4'h3);
    mode_sel = 2'd1;
    send(12'd2048, 12'd0, 12'd1024, 1'b0, 4'h4);
    n_cmp++;
    if (active_mode !== 2'd0) begin n_fail++; $display("FAIL mode_nosof: active_mode=%0d required 0", active_mode); end
    send(12'd2048, 12'd0, 12'd1024, 1'b1, 4'h5);
    n_cmp++;
    if (active_mode !== 2'd1) begin n_fail++; $display("FAIL mode_sof: active_mode=%0d required 1", active_mode); end
    get_out("mode_a");
    n_cmp++;
    if (got_rgb !== {8'd201, 8'd91, 8'd128} || got_sof !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_a_601: rgb=%h sof=%b required %h/1", got_rgb, got_sof, {8'd201, 8'd91, 8'd128});
    end
    get_out("mode_b");
    n_cmp++;
    if (got_rgb !== {8'd201, 8'd91, 8'd128} || got_sof !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_b_601: rgb=%h sof=%b required %h/0", got_rgb, got_sof, {8'd201, 8'd91, 8'd128});
    end
    get_out("mode_c");
    n_cmp++;
    if (got_rgb !== {8'd229, 8'd98, 8'd128} || got_user !== 4'h5) begin
      n_fail++;
      $display("FAIL mode_c_709: rgb=%h user=%h required %h/5", got_rgb, got_user, {8'd229, 8'd98, 8'd128});
    end
  endtask

  task automatic test_user_bank;
    for (int a = 0; a < 4; a++) cfg_write(2'(a), 13'd0);
    mode_sel = 2'd2;
    send(12'd1024, 12'd1000, 12'd1000, 1'b1, 4'h6);
    n_cmp++;
    if (active_mode !== 2'd2) begin n_fail++; $display("FAIL user_mode: active_mode=%0d required 2", active_mode); end
    get_out("user_zero");
    n_cmp++;
    if (got_rgb !== {8'd64, 8'd64, 8'd64}) begin
      n_fail++;
      $display("FAIL user_zero: rgb=%h required %h", got_rgb, {8'd64, 8'd64, 8'd64});
    end
    // Write RV in the same cycle as the SOF accept: the old (zero) RV must be used.
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 13'd1167;
    in_valid = 1'b1; y_in = 12'd2048; u_in = 12'd0; v_in = 12'd1024; in_sof = 1'b1; in_user = 4'h7;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    get_out("user_same_cycle");
    n_cmp++;
    if (got_rgb !== {8'd128, 8'd128, 8'd128}) begin
      n_fail++;
      $display("FAIL user_same_cycle: rgb=%h required %h", got_rgb, {8'd128, 8'd128, 8'd128});
    end
    send(12'd2048, 12'd0, 12'd1024, 1'b1, 4'h8);
    get_out("user_next_sof");
    n_cmp++;
    if (got_rgb !== {8'd201, 8'd128, 8'd128}) begin
      n_fail++;
      $display("FAIL user_next_sof: rgb=%h required %h", got_rgb, {8'd201, 8'd128, 8'd128});
    end
    mode_sel = 2'd3;
    send(12'd2048, 12'd0, 12'd1024, 1'b1, 4'h9);
    n_cmp++;
    if (active_mode !== 2'd0) begin n_fail++; $display("FAIL mode3_active: active_mode=%0d required 0", active_mode); end
    get_out("mode3");
    n_cmp++;
    if (got_rgb !== {8'd201, 8'd91, 8'd128}) begin
      n_fail++;
      $display("FAIL mode3_601: rgb=%h required %h", got_rgb, {8'd201, 8'd91, 8'd128});
    end
  endtask

  task automatic test_reset_mid_burst;
    logic seen = 1'b0;
    mode_sel = 2'd1;
    send(12'd2048, 12'd0, 12'd1024, 1'b1, 4'hA);
    n_cmp++;
    if (active_mode !== 2'd1) begin n_fail++; $display("FAIL rst_pre_mode: active_mode=%0d required 1", active_mode); end
    send(12'd2048, 12'd0, 12'd0, 1'b0, 4'hB);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mode_sel = 2'd0;
    n_cmp++;
    if (out_valid !== 1'b0 || active_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid: out_valid=%b active_mode=%0d required 0/0", out_valid, active_mode);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL rst_stale: out_valid=1 after reset required 0"); end
    send(12'd2048, 12'd0, 12'd1024, 1'b0, 4'hC);
    get_out("rst_after");
    n_cmp++;
    if (got_rgb !== {8'd201, 8'd91, 8'd128} || got_user !== 4'hC) begin
      n_fail++;
      $display("FAIL rst_after: rgb=%h user=%h required %h/c", got_rgb, got_user, {8'd201, 8'd91, 8'd128});
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; y_in = '0; u_in = '0; v_in = '0; in_sof = 1'b0;
    in_user = '0; mode_sel = 2'd0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    out_ready = 1'b1;
    test_reset;
    test_gray_latency;
    test_u_path;
    test_clamp;
    test_stall;
    test_mode_switch;
    test_user_bank;
    test_reset_mid_burst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
